// File: rtl/out_drain_unit.sv
// ---------------------------------------------------------------------------
// out_drain_unit
//
// Purpose:
//   Drains result rows from the output BRAM read port and serializes each
//   row (PE_COUNT lanes of DATA_WIDTH bits) onto a valid/ready word stream,
//   lane 0 first. A job starts with a one-cycle start pulse that carries a
//   base row address and a row count. Row addresses wrap modulo
//   2^ADDR_WIDTH. A zero-row job produces only a done pulse.
//
// Ports:
//   clk              : single clock
//   rst              : synchronous, active-high reset
//   start            : launch pulse, sampled only while idle
//   base_addr        : first row address, sampled with start
//   row_count        : rows to drain (0 .. 2^ADDR_WIDTH), sampled with start
//   busy             : job in progress
//   done             : one-cycle pulse at job end
//   bram_out_rd_en   : BRAM read enable (one cycle per row)
//   bram_out_rd_addr : BRAM read address
//   bram_out_rd_din  : BRAM read data, valid one cycle after rd_en
//   m_data           : stream word
//   m_valid          : stream valid
//   m_ready          : stream ready
//   m_last           : final word of the job
// ---------------------------------------------------------------------------
module out_drain_unit #(
  parameter int unsigned PE_COUNT   = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [ADDR_WIDTH:0]            row_count,
  output logic                           busy,
  output logic                           done,
  output logic                           bram_out_rd_en,
  output logic [ADDR_WIDTH-1:0]          bram_out_rd_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_out_rd_din,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last
);

  localparam int unsigned LANE_W = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PE_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_SEND
  } state_e;

  state_e                               state_q, state_d;
  logic [ADDR_WIDTH-1:0]                addr_q,  addr_d;
  logic [ADDR_WIDTH:0]                  rows_q,  rows_d;
  logic [LANE_W-1:0]                    lane_q,  lane_d;
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  row_q,   row_d;
  logic                                 done_q,  done_d;

  logic last_lane;
  assign last_lane = (lane_q == LAST_LANE);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rows_q  <= '0;
      lane_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rows_q  <= rows_d;
      lane_q  <= lane_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and datapath updates
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rows_d  = rows_q;
    lane_d  = lane_q;
    row_d   = row_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (row_count != '0) begin
            addr_d  = base_addr;
            rows_d  = row_count;
            state_d = S_RD;
          end else begin
            // Empty job: acknowledge without touching the BRAM.
            done_d = 1'b1;
          end
        end
      end

      S_RD: begin
        state_d = S_CAP;
      end

      S_CAP: begin
        row_d   = bram_out_rd_din;
        lane_d  = '0;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (m_ready) begin
          if (last_lane) begin
            if (rows_q > (ADDR_WIDTH+1)'(1)) begin
              rows_d  = rows_q - (ADDR_WIDTH+1)'(1);
              // Natural overflow gives the modulo-2^ADDR_WIDTH wrap.
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = S_RD;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registered state only (no m_ready feed-through)
  // -------------------------------------------------------------------------
  always_comb begin
    busy             = (state_q != S_IDLE);
    done             = done_q;
    bram_out_rd_en   = (state_q == S_RD);
    bram_out_rd_addr = (state_q == S_RD) ? addr_q : '0;
    m_valid          = (state_q == S_SEND);
    m_data           = (state_q == S_SEND) ? row_q[lane_q] : '0;
    m_last           = (state_q == S_SEND) && (rows_q == (ADDR_WIDTH+1)'(1))
                       && last_lane;
  end

endmodule

// File: tb/tb_out_drain_unit.sv
module tb_out_drain_unit;

  localparam int PE = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       row_count;
  logic              busy, done;
  logic              bram_out_rd_en;
  logic [AW-1:0]     bram_out_rd_addr;
  logic [PE*DW-1:0]  bram_out_rd_din;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  int tests = 0;
  int fails = 0;

  logic [PE*DW-1:0] mem [DEPTH];
  logic [DW:0]      exp_q[$];   // {last, data}
  logic [AW-1:0]    addr_q[$];

  always #5 clk = ~clk;

  out_drain_unit #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .base_addr        (base_addr),
    .row_count        (row_count),
    .busy             (busy),
    .done             (done),
    .bram_out_rd_en   (bram_out_rd_en),
    .bram_out_rd_addr (bram_out_rd_addr),
    .bram_out_rd_din  (bram_out_rd_din),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_last           (m_last)
  );

  // BRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (bram_out_rd_en) bram_out_rd_din <= mem[bram_out_rd_addr];
  end

  // Launch a job and record the expected address sequence and word stream.
  task automatic drive_start(input int base, input int count);
    logic [AW-1:0] a;
    logic [PE*DW-1:0] row;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = AW'(base);
    row_count = (AW+1)'(count);
    for (int r = 0; r < count; r++) begin
      a = AW'(base + r);
      addr_q.push_back(a);
      row = mem[a];
      for (int l = 0; l < PE; l++)
        exp_q.push_back({(r == count - 1) && (l == PE - 1), row[l*DW +: DW]});
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Scoreboard: compares every handshake and every BRAM read, and checks
  // that a stalled word holds steady.
  task automatic monitor();
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic          held_last = 1'b0;
    logic [DW:0]   e;
    logic [AW-1:0] ea;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          tests++;
          if (m_valid !== 1'b1 || m_data !== held_data || m_last !== held_last) begin
            fails++;
            $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     m_valid, m_data, m_last, held_data, held_last);
          end
        end
        if (m_valid && m_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL word_extra: data=%h last=%b, required no word", m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            if ({m_last, m_data} !== e) begin
              fails++;
              $display("FAIL word: last=%b data=%h, required last=%b data=%h",
                       m_last, m_data, e[DW], e[DW-1:0]);
            end
          end
        end
        if (bram_out_rd_en) begin
          tests++;
          if (addr_q.size() == 0) begin
            fails++;
            $display("FAIL rd_extra: addr=%0d, required no read", bram_out_rd_addr);
          end else begin
            ea = addr_q.pop_front();
            if (bram_out_rd_addr !== ea) begin
              fails++;
              $display("FAIL rd_addr: addr=%0d, required %0d", bram_out_rd_addr, ea);
            end
          end
        end
        stall_prev = m_valid && !m_ready;
        held_data  = m_data;
        held_last  = m_last;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, bram_out_rd_en, bram_out_rd_addr, m_data, m_valid, m_last} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b addr=%0d data=%h valid=%b last=%b, required all 0",
               busy, done, bram_out_rd_en, bram_out_rd_addr, m_data, m_valid, m_last);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_row();
    logic [4:0] got, want;
    m_ready = 1'b1;
    mem[5] = {32'h44, 32'h33, 32'h22, 32'h11};
    drive_start(5, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      want = {k <= 6, k == 7, k == 1, (k >= 3) && (k <= 6), k == 6};
      got  = {busy, done, bram_out_rd_en, m_valid, m_last};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL single_timing cycle T+%0d: busy,done,rd_en,valid,last=%b, required %b", k, got, want);
      end
      if (k == 1) begin
        tests++;
        if (bram_out_rd_addr !== AW'(5)) begin
          fails++;
          $display("FAIL single_addr: %0d, required 5", bram_out_rd_addr);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int got = 0;
    m_ready = 1'b1;
    drive_start(1023, 3);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin got = c; break; end
    end
    tests++;
    if (got != 19) begin
      fails++;
      $display("FAIL wrap_done_cycle: T+%0d, required T+19", got);
    end
    tests++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_drained: words left %0d addrs left %0d, required 0 0", exp_q.size(), addr_q.size());
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    drive_start(100, 5);
    for (int c = 1; c <= 600; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin got = c; break; end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    tests++;
    if (got == 0) begin
      fails++;
      $display("FAIL bp_done: no done in 600 cycles, required done");
    end
    tests++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      fails++;
      $display("FAIL bp_drained: words left %0d addrs left %0d, required 0 0", exp_q.size(), addr_q.size());
    end
  endtask

  task automatic test_zero_and_busy();
    int got = 0;
    m_ready = 1'b1;
    drive_start(9, 0);
    @(negedge clk);
    tests++;
    if ({done, busy, bram_out_rd_en} !== 3'b100) begin
      fails++;
      $display("FAIL zero_count: done,busy,rd_en=%b, required 100", {done, busy, bram_out_rd_en});
    end
    @(negedge clk);
    tests++;
    if ({done, busy, bram_out_rd_en} !== 3'b000) begin
      fails++;
      $display("FAIL zero_after: done,busy,rd_en=%b, required 000", {done, busy, bram_out_rd_en});
    end
    drive_start(200, 2);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(7); row_count = (AW+1)'(5);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin got = c; break; end
    end
    tests++;
    if (got == 0) begin
      fails++;
      $display("FAIL busy_start_done: no done, required done");
    end
    repeat (8) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || addr_q.size() != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL busy_start_ignored: busy=%b addrs left %0d words left %0d, required 0 0 0",
               busy, addr_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_job();
    int got = 0;
    int seen = 0;
    m_ready = 1'b1;
    drive_start(300, 4);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (m_valid) begin seen = 1; break; end
    end
    tests++;
    if (seen == 0) begin
      fails++;
      $display("FAIL rstmid_valid: m_valid never rose, required 1");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({busy, done, bram_out_rd_en, bram_out_rd_addr, m_data, m_valid, m_last} !== '0) begin
      fails++;
      $display("FAIL rstmid_outputs: busy=%b done=%b rd_en=%b addr=%0d data=%h valid=%b last=%b, required all 0",
               busy, done, bram_out_rd_en, bram_out_rd_addr, m_data, m_valid, m_last);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done || m_valid || busy || bram_out_rd_en) seen = 2;
    end
    tests++;
    if (seen == 2) begin
      fails++;
      $display("FAIL rstmid_quiet: activity after reset, required none");
    end
    drive_start(40, 2);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin got = c; break; end
    end
    tests++;
    if (got != 13 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rstmid_fresh: done at T+%0d words left %0d, required T+13 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_max_job();
    int got = 0;
    m_ready = 1'b1;
    drive_start(0, 1024);
    for (int c = 1; c <= 7000; c++) begin
      @(negedge clk);
      if (done) begin got = c; break; end
    end
    tests++;
    if (got != 6145) begin
      fails++;
      $display("FAIL max_done_cycle: T+%0d, required T+6145", got);
    end
    tests++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      fails++;
      $display("FAIL max_drained: words left %0d addrs left %0d, required 0 0", exp_q.size(), addr_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    row_count = '0;
    m_ready = 1'b0;
    bram_out_rd_din = '0;
    for (int i = 0; i < DEPTH; i++)
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
    fork
      monitor();
    join_none
    test_reset();
    test_single_row();
    test_wrap();
    test_backpressure();
    test_zero_and_busy();
    test_reset_mid_job();
    test_max_job();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
